single_cycle_processor: RTL and testbench
=========================================

# single_cycle_processor

Single-cycle 64-bit LEGv8/ARMv8 subset core: fetch, decode, register read, ALU, data memory and writeback all complete within one clock period. It is the top-level compute block of the processor design. It contains its own instruction memory, data memory and register file, all preloadable by the bench through fixed hierarchical names. It is the baseline reference for the later pipelined core.

## Interface
Parameters:
- IMEM_WORDS, 256: instruction memory depth in 32-bit words.
- DMEM_WORDS, 256: data memory depth in 64-bit doublewords.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- uitgang  output  1  registered zero flag: 1 when the ALU result of the last executed instruction was zero.

Fixed hierarchical names:
- Register file instance `registers`, with array `regfile[0:31]` of 64 bits.
- Instruction memory instance `instruction_memory`, with array `memory[0:IMEM_WORDS-1]` of 32 bits.
- Top-level net `pc_out` (64 bits): the current PC.
- Top-level net `instruction` (32 bits): the fetched word.

## Operation
Fetch and register file:
- Fetch: instruction = memory[pc_out[9:2]].
- Register file: 2 combinational read ports and 1 write port.
- X31 reads as 0. Writes to X31 are discarded.

Decode (opcode in bits [31:21]):
- ADD 10001011000 / SUB 11001011000: Rd = Rn ± Rm.
- AND 10001010000 / ORR 10101010000: Rd = Rn &/| Rm (configurable, see below).
- ADDI 1001000100x / SUBI 1101000100x: Rd = Rn ± zero-extended imm12 [21:10].
- LDUR 11111000010: Rt = DMEM[Rn + sign-extended imm9 [20:12]].
- STUR 11111000000: DMEM[...] = Rt.
- CBZ 10110100xxx / CBNZ 10110101xxx: test Rt [4:0]. Target = PC + (sign-extended imm19 [23:5] << 2).
- B 000101xxxxx: target = PC + (sign-extended imm26 << 2).
- Any other encoding, including 0x00000000: NOP. No register or memory write, PC += 4, uitgang unchanged.

Data memory and arithmetic:
- Data memory is indexed by byte address bits [10:3]. Unaligned low bits are ignored.
- All arithmetic is 64-bit two's-complement and wraps silently. No flags register exists.

Branch conditions:
- CBZ is taken iff Rt == 0.
- CBNZ is taken iff Rt != 0.
- The ALU evaluates Rt pass-through for CB instructions, so uitgang reflects (Rt == 0).

Reset:
- Reset clears only pc_out (to 0) and uitgang (to 0).
- The register file and both memories are not reset, so the bench can preload them at time 0.

## Timing
- Each instruction takes exactly 1 cycle: combinational from pc_out to next-PC and write data. PC, register write, memory write and uitgang all commit on the same rising edge.
- Register read-during-write in the same cycle returns the old value. Correct because each instruction is single-cycle.
- Reset asserted mid-run: pc_out returns to 0 asynchronously, with no partial write. Execution restarts at address 0 on the first edge after deassertion.
- PC wraps modulo 2^64. Fetch uses only the index bits, so the address space aliases.

## Configuration
- `SCP_LOGIC_OPS_EN` defined: AND and ORR are decoded and executed.
- `SCP_LOGIC_OPS_EN` not defined: AND and ORR are treated as NOPs (no write, PC += 4). Saves the logic-unit mux.

## Structure
- Package `scp_pkg`: opcode constants, ALU-operation enum (ADD, SUB, AND, ORR, PASSB), XLEN = 64 and instruction-width constants.
- Sub-modules: register file (instance `registers`) and instruction memory (instance `instruction_memory`).
- One further sub-module is natural: `scp_alu` (64-bit, op enum in, result and zero out).
- Control decode and data memory stay in the top.

## Test plan
- CBZ: preload X2 = 80, X16 = 2, X18 = 1.
  - SUB X16,X16,X18 → X16 = 1.
  - CBZ X16,#24 → not taken, PC += 4.
  - SUB → X16 = 0.
  - CBZ X16,#16 → PC += 16, skipping 3 words.
  - ADD X16,X16,X2 → X16 = 80.
- CBNZ: X16 = 80.
  - SUBI X16,X16,#80 → X16 = 0, uitgang = 1.
  - CBNZ #24 → not taken.
  - ADD X16,X16,X18 → X16 = 1.
  - CBNZ #16 → taken.
  - Skipped 0x00000000 words have no effect.
- Memory: STUR X2,[X31,#8] then LDUR X5,[X31,#8] → X5 = 80. ADD X31,X2,X2 → X31 still reads 0.
- Reset: drive reset low for 15 ns at start → pc_out = 0 and uitgang = 0 during reset, preloaded regfile values intact. Reassert mid-run → pc_out = 0 immediately.
- Branch backwards: B with imm26 = -2 at PC 0x10 → PC = 0x08.
- Config: with `SCP_LOGIC_OPS_EN`, ORR X3,X2,X18 → X3 = 81. Without it, X3 is unchanged.

Source files
------------

// File: rtl/scp_pkg.sv
// Shared constants for the single-cycle LEGv8 core: opcodes, ALU operations, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scp_pkg;

    localparam int XLEN       = 64;
    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Full 11-bit opcodes (instruction[31:21])
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Shorter opcodes, matched against the top bits only
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;   // instruction[31:22]
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;   // instruction[31:22]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;      // instruction[31:24]
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;      // instruction[31:24]
    localparam logic [5:0]  OP_B    = 6'b000101;        // instruction[31:26]

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_PASSB
    } alu_op_t;

    // Conditional-branch byte offset: sign-extended imm19 scaled to words
    function automatic logic [XLEN-1:0] cb_offset(input logic [INSTR_W-1:0] instr);
        return {{43{instr[23]}}, instr[23:5], 2'b00};
    endfunction

    // Unconditional-branch byte offset: sign-extended imm26 scaled to words
    function automatic logic [XLEN-1:0] b_offset(input logic [INSTR_W-1:0] instr);
        return {{36{instr[25]}}, instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/scp_alu.sv
// 64-bit ALU: add, subtract, optional AND/ORR, and B pass-through with zero detect.
// Latency: purely combinational.
// Backpressure: none.
module scp_alu
    import scp_pkg::*;
(
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // Operation select; without the logic-op build, AND/ORR never reach here
    always_comb begin
        result = b;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
`ifdef SCP_LOGIC_OPS_EN
            ALU_AND:   result = a & b;
            ALU_ORR:   result = a | b;
`endif
            ALU_PASSB: result = b;
            default:   result = b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/single_cycle_processor_imem.sv
// Instruction memory, 32-bit words, combinational read by word index.
// Latency: read combinational; optional load port writes on the rising edge.
// Backpressure: none.
module single_cycle_processor_imem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    // Not reset: normally preloaded hierarchically before execution starts
    logic [31:0] memory [0:WORDS-1];

    assign data = memory[addr];

    // Load port; the core ties it off, so program memory is read-only at run time
    always_ff @(posedge clock) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/single_cycle_processor_regfile.sv
// 32 x 64-bit register file, two combinational read ports, one write port; X31 is zero.
// Latency: reads combinational, write commits on the rising edge.
// Backpressure: none.
module single_cycle_processor_regfile
    import scp_pkg::*;
(
    input  logic                  clock,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [XLEN-1:0]       rd1,
    output logic [XLEN-1:0]       rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [XLEN-1:0]       wd
);

    // Not reset: contents are preloaded from outside at time 0
    logic [XLEN-1:0] regfile [0:NUM_REGS-1];

    assign rd1 = (ra1 == 5'd31) ? '0 : regfile[ra1];
    assign rd2 = (ra2 == 5'd31) ? '0 : regfile[ra2];

    // Single write port; writes aimed at X31 are dropped
    always_ff @(posedge clock) begin
        if (we && (wa != 5'd31)) begin
            regfile[wa] <= wd;
        end
    end

endmodule

// File: rtl/single_cycle_processor.sv
// Single-cycle LEGv8 subset core; AND/ORR decoded only when SCP_LOGIC_OPS_EN is defined.
// Latency: one instruction per clock; PC, register, memory and flag commit on the same edge.
// Backpressure: none; asynchronous active-low reset holds PC at 0 and blocks all writes.
module single_cycle_processor
    import scp_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic clock,
    input  logic reset,
    output logic uitgang
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0]    pc_out;
    logic [INSTR_W-1:0] instruction;
    logic [XLEN-1:0]    pc_next;

    logic [XLEN-1:0]    dmem [0:DMEM_WORDS-1];

    logic [REG_ADDR_W-1:0] ra2;
    logic [XLEN-1:0]       rd1, rd2, wd;
    logic [XLEN-1:0]       alu_b, alu_res;
    logic                  alu_zero;
    alu_op_t               alu_op;
    logic                  reg_we, mem_we, mem_to_reg, flag_we;
    logic                  is_cbz, is_cbnz, is_b;

    single_cycle_processor_imem #(.WORDS(IMEM_WORDS)) instruction_memory (
        .clock (clock),
        .addr  (pc_out[IW+1:2]),
        .data  (instruction),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0)
    );

    single_cycle_processor_regfile registers (
        .clock (clock),
        .ra1   (instruction[9:5]),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (reg_we && reset),
        .wa    (instruction[4:0]),
        .wd    (wd)
    );

    scp_alu alu (
        .op     (alu_op),
        .a      (rd1),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Control decode; anything unrecognised falls through as a NOP
    always_comb begin
        alu_op     = ALU_ADD;
        alu_b      = rd2;
        ra2        = instruction[20:16];
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        flag_we    = 1'b0;
        is_cbz     = 1'b0;
        is_cbnz    = 1'b0;
        is_b       = 1'b0;
        if (instruction[31:21] == OP_ADD) begin
            reg_we  = 1'b1;
            flag_we = 1'b1;
        end else if (instruction[31:21] == OP_SUB) begin
            alu_op  = ALU_SUB;
            reg_we  = 1'b1;
            flag_we = 1'b1;
`ifdef SCP_LOGIC_OPS_EN
        end else if (instruction[31:21] == OP_AND) begin
            alu_op  = ALU_AND;
            reg_we  = 1'b1;
            flag_we = 1'b1;
        end else if (instruction[31:21] == OP_ORR) begin
            alu_op  = ALU_ORR;
            reg_we  = 1'b1;
            flag_we = 1'b1;
`endif
        end else if (instruction[31:22] == OP_ADDI) begin
            alu_b   = {52'd0, instruction[21:10]};
            reg_we  = 1'b1;
            flag_we = 1'b1;
        end else if (instruction[31:22] == OP_SUBI) begin
            alu_op  = ALU_SUB;
            alu_b   = {52'd0, instruction[21:10]};
            reg_we  = 1'b1;
            flag_we = 1'b1;
        end else if (instruction[31:21] == OP_LDUR) begin
            alu_b      = {{55{instruction[20]}}, instruction[20:12]};
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            flag_we    = 1'b1;
        end else if (instruction[31:21] == OP_STUR) begin
            ra2     = instruction[4:0];
            alu_b   = {{55{instruction[20]}}, instruction[20:12]};
            mem_we  = 1'b1;
            flag_we = 1'b1;
        end else if (instruction[31:24] == OP_CBZ) begin
            ra2     = instruction[4:0];
            alu_op  = ALU_PASSB;
            flag_we = 1'b1;
            is_cbz  = 1'b1;
        end else if (instruction[31:24] == OP_CBNZ) begin
            ra2     = instruction[4:0];
            alu_op  = ALU_PASSB;
            flag_we = 1'b1;
            is_cbnz = 1'b1;
        end else if (instruction[31:26] == OP_B) begin
            // B does not use the ALU, so the zero flag keeps its last value
            is_b = 1'b1;
        end
    end

    // Next PC: branch target when taken, otherwise the following word
    always_comb begin
        pc_next = pc_out + 64'd4;
        if (is_b) begin
            pc_next = pc_out + b_offset(instruction);
        end else if ((is_cbz && alu_zero) || (is_cbnz && !alu_zero)) begin
            pc_next = pc_out + cb_offset(instruction);
        end
    end

    assign wd = mem_to_reg ? dmem[alu_res[DW+2:3]] : alu_res;

    // Data memory store; index ignores the low three byte-address bits
    always_ff @(posedge clock) begin
        if (mem_we && reset) begin
            dmem[alu_res[DW+2:3]] <= rd2;
        end
    end

    // Architectural PC and zero flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_out  <= '0;
            uitgang <= 1'b0;
        end else begin
            pc_out <= pc_next;
            if (flag_we) begin
                uitgang <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_single_cycle_processor.sv
// Directed program checks plus a randomized program compared with an instruction-level model.
// Latency: one instruction retired per clock.
// Backpressure: none.
module tb_single_cycle_processor;

    logic clock;
    logic reset;
    logic uitgang;

    int total  = 0;
    int passes = 0;

    // Reference model state
    logic [31:0] m_imem [0:255];
    logic [63:0] m_dmem [0:255];
    logic [63:0] m_reg  [0:31];
    logic [63:0] m_pc;
    logic        m_z;

    single_cycle_processor #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clock   (clock),
        .reset   (reset),
        .uitgang (uitgang)
    );

    initial begin
        clock = 1'b0;
        #2;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                           input logic [4:0] rt);
        return {op, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    function automatic logic [63:0] rdx(input logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : m_reg[r];
    endfunction

    // One instruction, evaluated straight from the ISA rules
    task automatic model_step();
        logic [31:0] w;
        logic [63:0] rn, rm, rt, res, nxt;
        logic        logic_ops;
        w  = m_imem[m_pc[9:2]];
        rn = rdx(w[9:5]);
        rm = rdx(w[20:16]);
        rt = rdx(w[4:0]);
        nxt = m_pc + 64'd4;
`ifdef SCP_LOGIC_OPS_EN
        logic_ops = 1'b1;
`else
        logic_ops = 1'b0;
`endif
        if (w[31:21] == 11'b10001011000) begin
            res = rn + rm; if (w[4:0] != 31) m_reg[w[4:0]] = res; m_z = (res == 0);
        end else if (w[31:21] == 11'b11001011000) begin
            res = rn - rm; if (w[4:0] != 31) m_reg[w[4:0]] = res; m_z = (res == 0);
        end else if (logic_ops && w[31:21] == 11'b10001010000) begin
            res = rn & rm; if (w[4:0] != 31) m_reg[w[4:0]] = res; m_z = (res == 0);
        end else if (logic_ops && w[31:21] == 11'b10101010000) begin
            res = rn | rm; if (w[4:0] != 31) m_reg[w[4:0]] = res; m_z = (res == 0);
        end else if (w[31:22] == 10'b1001000100) begin
            res = rn + 64'(w[21:10]); if (w[4:0] != 31) m_reg[w[4:0]] = res; m_z = (res == 0);
        end else if (w[31:22] == 10'b1101000100) begin
            res = rn - 64'(w[21:10]); if (w[4:0] != 31) m_reg[w[4:0]] = res; m_z = (res == 0);
        end else if (w[31:21] == 11'b11111000010) begin
            res = rn + 64'($signed(w[20:12]));
            if (w[4:0] != 31) m_reg[w[4:0]] = m_dmem[res[10:3]];
            m_z = (res == 0);
        end else if (w[31:21] == 11'b11111000000) begin
            res = rn + 64'($signed(w[20:12]));
            m_dmem[res[10:3]] = rt;
            m_z = (res == 0);
        end else if (w[31:24] == 8'b10110100) begin
            m_z = (rt == 0);
            if (rt == 0) nxt = m_pc + 64'($signed(w[23:5])) * 4;
        end else if (w[31:24] == 8'b10110101) begin
            m_z = (rt == 0);
            if (rt != 0) nxt = m_pc + 64'($signed(w[23:5])) * 4;
        end else if (w[31:26] == 6'b000101) begin
            nxt = m_pc + 64'($signed(w[25:0])) * 4;
        end
        m_pc = nxt;
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [18:0] off19;
        logic [25:0] off26;
        off19 = 19'($signed(int'($urandom_range(0, 12)) - 6));
        off26 = 26'($signed(int'($urandom_range(0, 12)) - 6));
        case ($urandom_range(0, 11))
            0:  w = enc_r(11'b10001011000, rreg(), rreg(), rreg());
            1:  w = enc_r(11'b11001011000, rreg(), rreg(), rreg());
            2:  w = enc_r(11'b10001010000, rreg(), rreg(), rreg());
            3:  w = enc_r(11'b10101010000, rreg(), rreg(), rreg());
            4:  w = enc_i(10'b1001000100, 12'($urandom_range(0, 4095)), rreg(), rreg());
            5:  w = enc_i(10'b1101000100, 12'($urandom_range(0, 3)), rreg(), rreg());
            6:  w = enc_d(11'b11111000010, 9'($urandom_range(0, 511)), rreg(), rreg());
            7:  w = enc_d(11'b11111000000, 9'($urandom_range(0, 511)), rreg(), rreg());
            8:  w = enc_cb(8'b10110100, off19, rreg());
            9:  w = enc_cb(8'b10110101, off19, rreg());
            10: w = enc_b(off26);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic hold_reset_and_clear();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            dut.instruction_memory.memory[i] = 32'd0;
            dut.dmem[i] = 64'd0;
        end
    endtask

    task automatic preload_reg(input int r, input logic [63:0] v);
        dut.registers.regfile[r] = v;
        m_reg[r] = v;
    endtask

    initial begin
        logic [63:0] exp_x3;
        logic [63:0] exp_pc [1:14];
        exp_pc = '{64'd4, 64'd8, 64'd12, 64'd28, 64'd32, 64'd36, 64'd40,
                   64'd44, 64'd60, 64'd64, 64'd68, 64'd72, 64'd76, 64'd80};
`ifdef SCP_LOGIC_OPS_EN
        exp_x3 = 64'd81;
`else
        exp_x3 = 64'h33;
`endif

        // ---------------- directed program ----------------
        hold_reset_and_clear();
        for (int i = 0; i < 32; i++) preload_reg(i, 64'h1000 + 64'(i));
        preload_reg(2, 64'd80);
        preload_reg(16, 64'd2);
        preload_reg(18, 64'd1);
        preload_reg(3, 64'h33);
        preload_reg(31, 64'hDEAD);
        dut.instruction_memory.memory[0]  = enc_r(11'b11001011000, 5'd18, 5'd16, 5'd16);
        dut.instruction_memory.memory[1]  = enc_cb(8'b10110100, 19'd6, 5'd16);
        dut.instruction_memory.memory[2]  = enc_r(11'b11001011000, 5'd18, 5'd16, 5'd16);
        dut.instruction_memory.memory[3]  = enc_cb(8'b10110100, 19'd4, 5'd16);
        dut.instruction_memory.memory[7]  = enc_r(11'b10001011000, 5'd2, 5'd16, 5'd16);
        dut.instruction_memory.memory[8]  = enc_i(10'b1101000100, 12'd80, 5'd16, 5'd16);
        dut.instruction_memory.memory[9]  = enc_cb(8'b10110101, 19'd6, 5'd16);
        dut.instruction_memory.memory[10] = enc_r(11'b10001011000, 5'd18, 5'd16, 5'd16);
        dut.instruction_memory.memory[11] = enc_cb(8'b10110101, 19'd4, 5'd16);
        dut.instruction_memory.memory[15] = enc_d(11'b11111000000, 9'd8, 5'd31, 5'd2);
        dut.instruction_memory.memory[16] = enc_d(11'b11111000010, 9'd8, 5'd31, 5'd5);
        dut.instruction_memory.memory[17] = enc_r(11'b10001011000, 5'd2, 5'd2, 5'd31);
        dut.instruction_memory.memory[18] = enc_r(11'b10001011000, 5'd18, 5'd31, 5'd7);
        dut.instruction_memory.memory[19] = enc_r(11'b10101010000, 5'd18, 5'd2, 5'd3);

        #10;
        chk("reset_pc", dut.pc_out, 64'd0);
        chk("reset_uitgang", 64'(uitgang), 64'd0);
        chk("reset_x2_kept", dut.registers.regfile[2], 64'd80);
        chk("reset_x16_kept", dut.registers.regfile[16], 64'd2);
        #5 reset = 1'b1;

        for (int s = 1; s <= 14; s++) begin
            @(negedge clock);
            chk($sformatf("dir_pc_step%0d", s), dut.pc_out, exp_pc[s]);
            case (s)
                1:  begin chk("sub_x16_1", dut.registers.regfile[16], 64'd1);
                          chk("sub_flag0", 64'(uitgang), 64'd0); end
                2:  chk("cbz_nt_flag", 64'(uitgang), 64'd0);
                3:  begin chk("sub_x16_0", dut.registers.regfile[16], 64'd0);
                          chk("sub_flag1", 64'(uitgang), 64'd1); end
                4:  chk("cbz_t_flag", 64'(uitgang), 64'd1);
                5:  begin chk("add_x16_80", dut.registers.regfile[16], 64'd80);
                          chk("add_flag0", 64'(uitgang), 64'd0); end
                6:  begin chk("subi_x16_0", dut.registers.regfile[16], 64'd0);
                          chk("subi_flag1", 64'(uitgang), 64'd1); end
                8:  chk("add_x16_1", dut.registers.regfile[16], 64'd1);
                9:  chk("cbnz_t_flag", 64'(uitgang), 64'd0);
                10: chk("stur_dmem1", dut.dmem[1], 64'd80);
                11: chk("ldur_x5", dut.registers.regfile[5], 64'd80);
                12: chk("x31_store_dropped", dut.registers.regfile[31], 64'hDEAD);
                13: chk("x31_reads_zero", dut.registers.regfile[7], 64'd1);
                14: chk("orr_x3", dut.registers.regfile[3], exp_x3);
                default: ;
            endcase
        end
        chk("skipped_x1_untouched", dut.registers.regfile[1], 64'h1001);

        // Mid-run reset: PC drops at once, the edge under reset writes nothing
        #2 reset = 1'b0;
        #1;
        chk("midreset_pc_async", dut.pc_out, 64'd0);
        chk("midreset_flag", 64'(uitgang), 64'd0);
        @(posedge clock); #1;
        chk("midreset_pc_held", dut.pc_out, 64'd0);
        chk("midreset_no_write", dut.registers.regfile[16], 64'd1);
        @(negedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("restart_pc", dut.pc_out, 64'd4);
        chk("restart_x16", dut.registers.regfile[16], 64'd0);

        // ---------------- backwards branch ----------------
        hold_reset_and_clear();
        dut.instruction_memory.memory[4] = enc_b(26'h3FFFFFE);
        @(negedge clock); reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("b_at_0x10", dut.pc_out, 64'h10);
        @(negedge clock);
        chk("b_back_0x08", dut.pc_out, 64'h08);

        // ---------------- randomized program vs model ----------------
        hold_reset_and_clear();
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = rand_instr();
            dut.instruction_memory.memory[i] = m_imem[i];
            m_dmem[i] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            dut.dmem[i] = m_dmem[i];
        end
        for (int i = 0; i < 32; i++)
            preload_reg(i, (i < 4) ? 64'($urandom_range(0, 2)) : {$urandom, $urandom});
        m_pc = 64'd0;
        m_z  = 1'b0;
        @(negedge clock); reset = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            if (c == 250) begin
                #2 reset = 1'b0;
                #1;
                m_pc = 64'd0;
                m_z  = 1'b0;
                chk("rand_midreset_pc", dut.pc_out, m_pc);
                @(negedge clock); #1 reset = 1'b1;
            end
            @(negedge clock);
            model_step();
            chk($sformatf("rand_pc_c%0d", c), dut.pc_out, m_pc);
            chk($sformatf("rand_flag_c%0d", c), 64'(uitgang), 64'(m_z));
            if (c % 100 == 0) begin
                for (int r = 0; r < 31; r++)
                    chk($sformatf("rand_x%0d_c%0d", r, c), dut.registers.regfile[r], m_reg[r]);
            end
        end
        for (int i = 0; i < 256; i++)
            chk($sformatf("rand_dmem%0d", i), dut.dmem[i], m_dmem[i]);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
